// File: rtl/gcu_ready_dispatcher_if.sv
// Interface for the ready dispatcher: run control, scoreboard query and the dispatch channel.
// The master modport is the side that drives start/front_ready/dispatch_ready.
interface gcu_ready_dispatcher_if #(
  parameter int NODE_ID_W = 16
);
  logic                 start;
  logic [NODE_ID_W-1:0] last_node_id;
  logic [NODE_ID_W-1:0] query_node_id;
  logic                 front_ready;
  logic                 dispatch_valid;
  logic [NODE_ID_W-1:0] dispatch_node_id;
  logic                 dispatch_ready;
  logic                 busy;
  logic                 done;

  modport master (
    output start, last_node_id, front_ready, dispatch_ready,
    input  query_node_id, dispatch_valid, dispatch_node_id, busy, done
  );

  modport slave (
    input  start, last_node_id, front_ready, dispatch_ready,
    output query_node_id, dispatch_valid, dispatch_node_id, busy, done
  );
endinterface

// File: rtl/gcu_ready_dispatcher.sv
// Sweeps node IDs against the dependency scoreboard and queues each newly ready node
// exactly once into a fall-through FIFO that feeds the compute engine.
module gcu_ready_dispatcher #(
  parameter int NODE_ID_W  = 16,
  parameter int MAX_NODES  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  gcu_ready_dispatcher_if.slave bus
);
  localparam int IDX_W = $clog2(MAX_NODES);
  localparam int CNT_W = IDX_W + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LIM_MAX = IDX_W'(MAX_NODES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     scan_ptr;
  logic [IDX_W-1:0]     lim;
  logic [IDX_W-1:0]     lim_start;
  logic [CNT_W-1:0]     disp_cnt;
  logic [CNT_W-1:0]     lim_p1;
  logic [CNT_W-1:0]     cnt_after;
  logic [MAX_NODES-1:0] bitmap;
  logic [NODE_ID_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          fifo_cnt;
  logic                 fifo_full, fifo_empty;
  logic                 want, push, pop, start_ok;

  assign start_ok   = (state == IDLE) && bus.start;
  assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = !fifo_empty && bus.dispatch_ready;
  assign want       = (state == SCAN) && bus.front_ready && !bitmap[scan_ptr];
  assign push       = want && !fifo_full;
  assign lim_p1     = {1'b0, lim} + CNT_W'(1);
  assign cnt_after  = disp_cnt + CNT_W'(push);

  // IDs beyond the bitmap are never scanned, so the run limit saturates at MAX_NODES-1
  always_comb begin
    lim_start = LIM_MAX;
    if (bus.last_node_id < NODE_ID_W'(MAX_NODES)) begin
      lim_start = bus.last_node_id[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SCAN;
      SCAN:    if (cnt_after == lim_p1) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A ready node that finds the FIFO full holds the pointer so it is retried next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_ptr <= '0;
      lim      <= '0;
      disp_cnt <= '0;
      bitmap   <= '0;
    end else if (start_ok) begin
      scan_ptr <= '0;
      lim      <= lim_start;
      disp_cnt <= '0;
      bitmap   <= '0;
    end else if (state == SCAN) begin
      if (!(want && fifo_full)) begin
        scan_ptr <= (scan_ptr == lim) ? '0 : scan_ptr + IDX_W'(1);
      end
      if (push) begin
        bitmap[scan_ptr] <= 1'b1;
        disp_cnt         <= cnt_after;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + (AW+1)'(1);
      end else if (pop && !push) begin
        fifo_cnt <= fifo_cnt - (AW+1)'(1);
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= NODE_ID_W'(scan_ptr);
  end

  assign bus.query_node_id    = NODE_ID_W'(scan_ptr);
  assign bus.dispatch_valid   = !fifo_empty;
  assign bus.dispatch_node_id = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign bus.busy             = (state == SCAN) || (state == DRAIN);
  assign bus.done             = (state == DONE);
endmodule

// File: tb/tb_gcu_ready_dispatcher.sv
// Bench for gcu_ready_dispatcher: table-driven full runs, hand-built corner sequences and
// randomized runs, all checked each cycle against a queue-based model of the dispatch rules.
module tb_gcu_ready_dispatcher;
  localparam int NODE_ID_W  = 16;
  localparam int MAX_NODES  = 1024;
  localparam int FIFO_DEPTH = 8;
  localparam int IDX_W      = $clog2(MAX_NODES);

  typedef struct {
    int last;
    int exp_count;
    int exp_done_at;
    int exp_final_id;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [MAX_NODES-1:0] ready_mask;
  bit                   rand_ready;
  int                   dr_mode;
  int                   passed = 0;
  int                   total  = 0;
  int                   got_ids[$];
  int                   exp_ids[$];
  int                   done_at;

  // Model: phase 0 idle, 1 sweeping, 2 draining, 3 done pulse
  int m_phase, m_lim, m_ptr, m_cnt;
  bit m_seen [MAX_NODES];
  int m_q[$];

  gcu_ready_dispatcher_if #(.NODE_ID_W(NODE_ID_W)) bus ();

  gcu_ready_dispatcher #(
    .NODE_ID_W (NODE_ID_W),
    .MAX_NODES (MAX_NODES),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard stand-in: answers the query combinationally from ready_mask
  always_comb begin
    bus.front_ready = 1'b0;
    if (bus.query_node_id < NODE_ID_W'(MAX_NODES)) begin
      bus.front_ready = ready_mask[bus.query_node_id[IDX_W-1:0]];
    end
  end

  task automatic compare(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_lim   = 0;
    m_q.delete();
    foreach (m_seen[i]) m_seen[i] = 1'b0;
  endtask

  task automatic model_step(input bit st, input int last, input bit dr);
    bit pop, want, full;
    pop  = (m_q.size() > 0) && dr;
    want = 1'b0;
    full = 1'b0;
    case (m_phase)
      0: if (st) begin
        m_phase = 1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_lim   = (last > MAX_NODES - 1) ? MAX_NODES - 1 : last;
        foreach (m_seen[i]) m_seen[i] = 1'b0;
      end
      1: begin
        want = ready_mask[m_ptr] && !m_seen[m_ptr];
        full = (m_q.size() == FIFO_DEPTH);
        if (pop) void'(m_q.pop_front());
        if (want && !full) begin
          m_q.push_back(m_ptr);
          m_seen[m_ptr] = 1'b1;
          m_cnt++;
        end
        if (!(want && full)) m_ptr = (m_ptr == m_lim) ? 0 : m_ptr + 1;
        if (m_cnt == m_lim + 1) m_phase = 2;
      end
      2: begin
        if (m_q.size() == 0) m_phase = 3;
        else if (pop) void'(m_q.pop_front());
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic checkOutput();
    int exp_valid;
    exp_valid = (m_q.size() > 0) ? 1 : 0;
    compare("dispatch_valid", int'(bus.dispatch_valid), exp_valid);
    compare("dispatch_node_id", int'(bus.dispatch_node_id), exp_valid ? m_q[0] : 0);
    compare("busy", int'(bus.busy), (m_phase == 1 || m_phase == 2) ? 1 : 0);
    compare("done", int'(bus.done), (m_phase == 3) ? 1 : 0);
    compare("query_node_id", int'(bus.query_node_id), m_ptr);
  endtask

  task automatic applyStimulus(input bit st, input int last);
    bit dr;
    case (dr_mode)
      0:       dr = 1'b1;
      1:       dr = 1'($urandom_range(0, 1));
      default: dr = 1'b0;
    endcase
    if (rand_ready) ready_mask[63:0] = {$urandom(), $urandom()};
    bus.start          = st;
    bus.last_node_id   = NODE_ID_W'(last);
    bus.dispatch_ready = dr;
    if (bus.dispatch_valid && dr) got_ids.push_back(int'(bus.dispatch_node_id));
    model_step(st, last, dr);
  endtask

  task automatic tick(input bit st, input int last);
    checkOutput();
    applyStimulus(st, last);
    @(negedge clk);
  endtask

  task automatic run_until_done(input int budget);
    bit seen_done;
    int cycles;
    seen_done = 1'b0;
    cycles    = 0;
    done_at   = -1;
    while (!seen_done && cycles < budget) begin
      if (m_phase == 3) seen_done = 1'b1;
      if (bus.done && done_at < 0) done_at = cycles;
      tick(1'b0, 0);
      cycles++;
    end
    compare("run_completes_in_budget", int'(seen_done), 1);
  endtask

  task automatic check_ids(input string name);
    compare({name, "_count"}, got_ids.size(), exp_ids.size());
    for (int i = 0; i < exp_ids.size() && i < got_ids.size(); i++) begin
      compare(name, got_ids[i], exp_ids[i]);
    end
  endtask

  task automatic begin_run(input int last);
    got_ids.delete();
    exp_ids.delete();
    tick(1'b1, last);
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{0,    1,    3,    0};
    vecs[1] = '{3,    4,    6,    3};
    vecs[2] = '{7,    8,    10,   7};
    vecs[3] = '{12,   13,   15,   12};
    vecs[4] = '{2000, 1024, 1026, 1023};

    rst_n              = 1'b0;
    ready_mask         = '0;
    rand_ready         = 1'b0;
    dr_mode            = 0;
    bus.start          = 1'b0;
    bus.last_node_id   = '0;
    bus.dispatch_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checkOutput();
    rst_n = 1'b1;
    @(negedge clk);

    // All-ready runs: IDs appear in order, done lands lim+3 cycles after the first sweep cycle
    ready_mask = '1;
    for (int v = 0; v < 5; v++) begin
      begin_run(vecs[v].last);
      run_until_done(4000);
      compare("tbl_count", got_ids.size(), vecs[v].exp_count);
      compare("tbl_done_at", done_at, vecs[v].exp_done_at);
      compare("tbl_final_id", (got_ids.size() > 0) ? got_ids[$] : -1, vecs[v].exp_final_id);
      for (int i = 0; i < got_ids.size(); i++) compare("tbl_order", got_ids[i], i);
    end

    // Dependency order: 3 first, then 1, then 0 and 2 on later sweeps
    ready_mask = '0;
    ready_mask[3] = 1'b1;
    begin_run(3);
    repeat (6) tick(1'b0, 0);
    ready_mask[1] = 1'b1;
    repeat (6) tick(1'b0, 0);
    ready_mask[0] = 1'b1;
    ready_mask[2] = 1'b1;
    run_until_done(200);
    exp_ids = '{3, 1, 0, 2};
    check_ids("dep_order");

    // Backpressure: FIFO fills with 0..7 and the sweep parks on node 8
    ready_mask = '1;
    dr_mode    = 2;
    begin_run(15);
    repeat (12) tick(1'b0, 0);
    compare("bp_stall_ptr", int'(bus.query_node_id), 8);
    compare("bp_head_valid", int'(bus.dispatch_valid), 1);
    compare("bp_head_id", int'(bus.dispatch_node_id), 0);
    compare("bp_none_taken", got_ids.size(), 0);
    dr_mode = 0;
    run_until_done(200);
    for (int i = 0; i < 16; i++) exp_ids.push_back(i);
    check_ids("bp_order");

    // Wrap: node 2 becomes ready only after the first sweep has passed it
    ready_mask    = '1;
    ready_mask[2] = 1'b0;
    begin_run(5);
    repeat (6) tick(1'b0, 0);
    compare("wrap_ptr", int'(bus.query_node_id), 0);
    ready_mask[2] = 1'b1;
    run_until_done(200);
    exp_ids = '{0, 1, 3, 4, 5, 2};
    check_ids("wrap_order");

    // Reset with three entries queued, then a fresh run starts again from ID 0
    ready_mask = '1;
    dr_mode    = 2;
    begin_run(15);
    repeat (3) tick(1'b0, 0);
    compare("rst_pre_valid", int'(bus.dispatch_valid), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare("rst_valid", int'(bus.dispatch_valid), 0);
    compare("rst_id", int'(bus.dispatch_node_id), 0);
    compare("rst_busy", int'(bus.busy), 0);
    compare("rst_query", int'(bus.query_node_id), 0);
    @(negedge clk);
    tick(1'b0, 0);
    rst_n   = 1'b1;
    dr_mode = 0;
    begin_run(4);
    run_until_done(200);
    exp_ids = '{0, 1, 2, 3, 4};
    check_ids("rst_rerun");

    // Start while busy with a different limit is ignored
    begin_run(5);
    tick(1'b0, 0);
    tick(1'b1, 30);
    run_until_done(200);
    exp_ids = '{0, 1, 2, 3, 4, 5};
    check_ids("busy_start");

    // Randomized readiness and backpressure; each node must come out exactly once
    rand_ready = 1'b1;
    dr_mode    = 1;
    for (int r = 0; r < 12; r++) begin
      int last;
      last = int'($urandom_range(0, 40));
      begin_run(last);
      run_until_done(5000);
      got_ids.sort();
      compare("rnd_count", got_ids.size(), last + 1);
      for (int i = 0; i < got_ids.size(); i++) compare("rnd_unique", got_ids[i], i);
    end
    rand_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
